// File: rtl/sseg_scan_controller.sv
// rtl/sseg_scan_controller.sv - bus-mapped multiplexed seven-segment scan controller
// Register file, prescaler/digit scan, brightness PWM, blink gating and registered pin drive.
module sseg_scan_controller #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_BITS   = 14,
  parameter int BLINK_BITS = 25
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [11:0]           addr_i,
  input  logic [7:0]            din_i,
  output logic [7:0]            dout_o,
  output logic [NUM_DIGITS-1:0] an_n_o,
  output logic [7:0]            sseg_n_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0] r_enable;
  logic [NUM_DIGITS-1:0] r_dp;
  logic [NUM_DIGITS-1:0] r_blink;
  logic                  r_raw;
  logic [3:0]            r_bright;
  logic [7:0]            r_digit [NUM_DIGITS];

  logic [DIV_BITS-1:0]   r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [BLINK_BITS-1:0] r_blink_cnt;

  logic                  w_wr;
  logic                  w_rd;
  logic [7:0]            w_rdata;
  logic [3:0]            w_level;
  logic                  w_lit;
  logic [7:0]            w_cur;
  logic [7:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_onehot;

  assign w_wr = en_i & we_i;
  assign w_rd = en_i & ~we_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_enable <= '0;
      r_dp     <= '0;
      r_blink  <= '0;
      r_raw    <= 1'b0;
      r_bright <= 4'hF;
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 8'h00;
    end else if (w_wr) begin
      case (addr_i)
        12'h000: r_enable <= din_i[NUM_DIGITS-1:0];
        12'h001: r_dp     <= din_i[NUM_DIGITS-1:0];
        12'h002: r_blink  <= din_i[NUM_DIGITS-1:0];
        12'h003: begin
          r_raw    <= din_i[0];
          r_bright <= din_i[7:4];
        end
        default: ;
      endcase
      for (int i = 0; i < NUM_DIGITS; i++)
        if (addr_i == 12'(8 + i)) r_digit[i] <= din_i;
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    case (addr_i)
      12'h000: w_rdata[NUM_DIGITS-1:0] = r_enable;
      12'h001: w_rdata[NUM_DIGITS-1:0] = r_dp;
      12'h002: w_rdata[NUM_DIGITS-1:0] = r_blink;
      12'h003: w_rdata = {r_bright, 3'b000, r_raw};
      default: ;
    endcase
    for (int i = 0; i < NUM_DIGITS; i++)
      if (addr_i == 12'(8 + i)) w_rdata = r_digit[i];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) dout_o <= 8'h00;
    else if (w_rd) dout_o <= w_rdata;
  end

  // Scan and blink counters are never touched by register writes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_presc     <= r_presc + 1'b1;
      r_blink_cnt <= r_blink_cnt + 1'b1;
      if (&r_presc) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  endfunction

  // Top four prescaler bits form the PWM phase compared against brightness.
  assign w_level = r_presc[DIV_BITS-1 -: 4];
  assign w_cur   = r_digit[r_idx];
  assign w_lit   = r_enable[r_idx] & ~(r_blink[r_idx] & r_blink_cnt[BLINK_BITS-1])
                   & (w_level <= r_bright);
  assign w_seg   = r_raw ? ~w_cur : {~r_dp[r_idx], hex_seg(w_cur[3:0])};

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      an_n_o   <= '1;
      sseg_n_o <= 8'hFF;
    end else if (w_lit) begin
      an_n_o   <= ~w_onehot;
      sseg_n_o <= w_seg;
    end else begin
      an_n_o   <= '1;
      sseg_n_o <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// tb/tb_sseg_scan_controller.sv - randomized bench with cycle-count reference model
// Model derives the expected pins from elapsed cycles and an address-indexed register image.
module tb_sseg_scan_controller;

  localparam int N   = 8;
  localparam int DIV = 4;
  localparam int BLK = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         we = 1'b0;
  logic [11:0]  addr = 12'h000;
  logic [7:0]   din = 8'h00;
  logic [7:0]   dout;
  logic [N-1:0] an_n;
  logic [7:0]   sseg_n;

  int n_cmp = 0;
  int n_err = 0;
  bit checking_on = 1'b0;

  sseg_scan_controller #(.NUM_DIGITS(N), .DIV_BITS(DIV), .BLINK_BITS(BLK)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .we_i(we), .addr_i(addr),
    .din_i(din), .dout_o(dout), .an_n_o(an_n), .sseg_n_o(sseg_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] hex_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic [7:0]  m_reg [16];
  int          m_cnt;
  logic [15:0] exp_out;
  logic [7:0]  exp_dout;

  function automatic bit valid_addr(input logic [11:0] a);
    return (a < 12'd4) || (a >= 12'd8 && a < 12'd8 + 12'(N));
  endfunction

  function automatic logic [7:0] write_mask(input logic [11:0] a);
    if (a == 12'd3) return 8'hF1;
    if (a < 12'd3) return 8'((1 << N) - 1);
    return 8'hFF;
  endfunction

  function automatic logic [15:0] model_out(input int c);
    int slot, level;
    bit blink_on, lit;
    logic [N-1:0] an;
    logic [7:0] seg, dig;
    slot     = (c >> DIV) % N;
    level    = (c % (1 << DIV)) >> (DIV - 4);
    blink_on = (c % (1 << BLK)) >= (1 << (BLK - 1));
    lit      = m_reg[0][slot] && !(m_reg[2][slot] && blink_on) && (level <= int'(m_reg[3][7:4]));
    if (!lit) return 16'hFFFF;
    an       = '1;
    an[slot] = 1'b0;
    dig      = m_reg[8 + slot];
    seg      = m_reg[3][0] ? ~dig : {~m_reg[1][slot], hex_tbl[dig[3:0]]};
    return {an, seg};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    <= 0;
      exp_out  <= 16'hFFFF;
      exp_dout <= 8'h00;
      for (int i = 0; i < 16; i++) m_reg[i] <= (i == 3) ? 8'hF0 : 8'h00;
    end else begin
      exp_out <= model_out(m_cnt);
      m_cnt   <= m_cnt + 1;
      if (en && !we) exp_dout <= valid_addr(addr) ? m_reg[addr[3:0]] : 8'h00;
      if (en && we && valid_addr(addr)) m_reg[addr[3:0]] <= din & write_mask(addr);
    end
  end

  always @(negedge clk) begin
    if (checking_on && rst_n) begin
      chk("scan", {an_n, sseg_n}, exp_out);
      chk("dout", {8'h00, dout}, {8'h00, exp_dout});
    end
  end

  task automatic bus_wr(input logic [11:0] a, input logic [7:0] d);
    en = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [11:0] a, input logic [7:0] exp);
    en = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    en = 1'b0;
    chk($sformatf("read_%03h", a), {8'h00, dout}, {8'h00, exp});
  endtask

  task automatic count_lit(input int n, output int lit);
    lit = 0;
    repeat (n) begin
      @(negedge clk);
      if (an_n !== '1) lit++;
    end
  endtask

  int lit;
  int waited;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_an", {8'h00, an_n}, 16'h00FF);
    chk("rst_sseg", {8'h00, sseg_n}, 16'h00FF);
    chk("rst_dout", {8'h00, dout}, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checking_on = 1'b1;

    for (int i = 0; i < N; i++) bus_wr(12'(8 + i), 8'(i));
    bus_wr(12'h000, 8'hFF);
    bus_wr(12'h003, 8'hF0);
    count_lit(128, lit);
    chk("duty_full", 16'(lit), 16'd128);

    bus_wr(12'h000, 8'hF0);
    count_lit(128, lit);
    chk("duty_half_en", 16'(lit), 16'd64);

    bus_wr(12'h000, 8'hFF);
    bus_wr(12'h001, 8'h05);
    repeat (128) @(negedge clk);
    bus_wr(12'h003, 8'h01);
    bus_wr(12'h008, 8'h7F);
    waited = 0;
    while (an_n !== 8'hFE && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("raw_d0_seen", 16'(waited < 300), 16'd1);
    chk("raw_d0_seg", {8'h00, sseg_n}, 16'h0080);

    bus_wr(12'h003, 8'h30);
    bus_wr(12'h008, 8'h00);
    count_lit(128, lit);
    chk("duty_b3", 16'(lit), 16'd32);

    bus_wr(12'h003, 8'hF0);
    bus_wr(12'h002, 8'h02);
    count_lit(256, lit);
    chk("duty_blink", 16'(lit), 16'd240);

    bus_wr(12'h000, 8'hF0);
    bus_wr(12'h003, 8'h31);
    bus_rd(12'h000, 8'hF0);
    bus_rd(12'h003, 8'h31);
    bus_rd(12'h00F, 8'h07);
    bus_rd(12'h100, 8'h00);
    bus_rd(12'h001, 8'h05);
    bus_wr(12'h003, 8'hFF);
    bus_rd(12'h003, 8'hF1);

    for (int k = 0; k < 3000; k++) begin
      int op;
      logic [11:0] a;
      op = int'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0: a = 12'($urandom_range(0, 3));
        1: a = 12'($urandom_range(8, 15));
        2: a = 12'($urandom_range(4, 7));
        default: a = 12'($urandom);
      endcase
      if (op <= 1) bus_wr(a, 8'($urandom));
      else if (op == 2) begin
        en = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        en = 1'b0;
      end else @(negedge clk);
    end

    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", {8'h00, an_n}, 16'h00FF);
    chk("async_sseg", {8'h00, sseg_n}, 16'h00FF);
    chk("async_dout", {8'h00, dout}, 16'h0000);
    checking_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
